// File: rtl/can_arbitration_field.sv
// CAN arbitration field transmitter: serialises ID/SRR/IDE/RTR MSB-first and
// compares each sampled bus bit against the driven bit to detect loss or error.
module can_arbitration_field #(
  parameter int EXT_EN   = 1,
  parameter int CHECK_ID = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sample_point,
  input  logic        Tx_request,
  input  logic        sof_complete,
  input  logic [28:0] identifier,
  input  logic        ide,
  input  logic        rtr,
  input  logic        rx_bit,
  output logic        bit_out,
  output logic [5:0]  bit_counter,
  output logic        arb_complete,
  output logic        arb_lost,
  output logic        bit_error,
  output logic        id_invalid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    DONE    = 3'd2,
    LOST    = 3'd3,
    ERROR   = 3'd4,
    INVALID = 3'd5
  } state_t;

  state_t      state_q;
  logic [31:0] shift_q;
  logic [5:0]  last_q;
  logic        bit_out_q;
  logic [5:0]  cnt_q;
  logic        complete_q;
  logic        lost_q;
  logic        error_q;
  logic        invalid_q;

  logic        is_ext_d;
  logic        id_bad_d;
  logic [31:0] frame_d;
  logic [5:0]  last_d;

  // Frame is left-aligned so the next bit to drive is always shift_q[31].
  always_comb begin
    is_ext_d = (EXT_EN != 0) && ide;
    id_bad_d = (CHECK_ID != 0) && !is_ext_d && (identifier[10:4] == 7'h7F);
    if (is_ext_d) begin
      frame_d = {identifier[28:18], 1'b1, 1'b1, identifier[17:0], rtr};
      last_d  = 6'd31;
    end else begin
      frame_d = {identifier[10:0], rtr, 1'b0, 19'd0};
      last_d  = 6'd12;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      last_q     <= 6'd12;
      bit_out_q  <= 1'b1;
      cnt_q      <= '0;
      complete_q <= 1'b0;
      lost_q     <= 1'b0;
      error_q    <= 1'b0;
      invalid_q  <= 1'b0;
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (Tx_request && sof_complete) begin
            if (id_bad_d) begin
              state_q   <= INVALID;
              invalid_q <= 1'b1;
            end else begin
              state_q   <= SEND;
              shift_q   <= {frame_d[30:0], 1'b0};
              last_q    <= last_d;
              bit_out_q <= frame_d[31];
              cnt_q     <= '0;
            end
          end
        end
        SEND: begin
          // Abort wins over a coincident sample point.
          if (!Tx_request) begin
            state_q   <= IDLE;
            bit_out_q <= 1'b1;
            cnt_q     <= '0;
          end else if (sample_point) begin
            if (rx_bit == bit_out_q) begin
              if (cnt_q == last_q) begin
                state_q    <= DONE;
                complete_q <= 1'b1;
                bit_out_q  <= 1'b1;
              end else begin
                cnt_q     <= cnt_q + 6'd1;
                bit_out_q <= shift_q[31];
                shift_q   <= {shift_q[30:0], 1'b0};
              end
            end else if (bit_out_q) begin
              state_q   <= LOST;
              lost_q    <= 1'b1;
              bit_out_q <= 1'b1;
            end else begin
              state_q   <= ERROR;
              error_q   <= 1'b1;
              bit_out_q <= 1'b1;
            end
          end
        end
        default: begin
          if (!Tx_request) begin
            state_q    <= IDLE;
            bit_out_q  <= 1'b1;
            cnt_q      <= '0;
            complete_q <= 1'b0;
            lost_q     <= 1'b0;
            error_q    <= 1'b0;
            invalid_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bit_out      = bit_out_q;
  assign bit_counter  = cnt_q;
  assign arb_complete = complete_q;
  assign arb_lost     = lost_q;
  assign bit_error    = error_q;
  assign id_invalid   = invalid_q;

endmodule

// File: tb/tb_can_arbitration_field.sv
// Bench for can_arbitration_field: a bit-sequence model fills a scoreboard
// queue at frame start; each sample point pops and compares the driven bit.
module tb_can_arbitration_field;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sample_point;
  logic        Tx_request;
  logic        sof_complete;
  logic [28:0] identifier;
  logic        ide;
  logic        rtr;
  logic        rx_bit;
  logic        bit_out;
  logic [5:0]  bit_counter;
  logic        arb_complete;
  logic        arb_lost;
  logic        bit_error;
  logic        id_invalid;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];

  can_arbitration_field #(.EXT_EN(1), .CHECK_ID(1)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .sample_point(sample_point), .Tx_request(Tx_request),
    .sof_complete(sof_complete), .identifier(identifier), .ide(ide),
    .rtr(rtr), .rx_bit(rx_bit), .bit_out(bit_out),
    .bit_counter(bit_counter), .arb_complete(arb_complete),
    .arb_lost(arb_lost), .bit_error(bit_error), .id_invalid(id_invalid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic bo, input logic [5:0] cnt,
                              input logic [3:0] flags);
    check({tag, ".bit_out"}, bit_out, bo);
    check({tag, ".cnt"}, bit_counter, cnt);
    check({tag, ".flags"}, {arb_complete, arb_lost, bit_error, id_invalid}, flags);
  endtask

  // Reference bit sequence, MSB first.
  task automatic push_frame(input logic [28:0] id, input logic x, input logic r);
    if (x) begin
      for (int i = 28; i >= 18; i--) exp_q.push_back(id[i]);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      for (int i = 17; i >= 0; i--) exp_q.push_back(id[i]);
      exp_q.push_back(r);
    end else begin
      for (int i = 10; i >= 0; i--) exp_q.push_back(id[i]);
      exp_q.push_back(r);
      exp_q.push_back(1'b0);
    end
  endtask

  task automatic start_frame(input logic [28:0] id, input logic x, input logic r, input bit valid);
    @(negedge clock);
    Tx_request   = 1'b1;
    sof_complete = 1'b1;
    identifier   = id;
    ide          = x;
    rtr          = r;
    if (valid) push_frame(id, x, r);
    @(posedge clock);
    #1;
    sof_complete = 1'b0;
    identifier   = ~id;
    ide          = ~x;
    rtr          = ~r;
  endtask

  task automatic do_bit(input int idx, input bit frc, input logic frc_val);
    logic e;
    @(negedge clock);
    if (exp_q.size() == 0) begin
      check("queue_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("bit[%0d]", idx), bit_out, e);
    end
    check($sformatf("cnt[%0d]", idx), bit_counter, idx[5:0]);
    sample_point = 1'b1;
    rx_bit       = frc ? frc_val : bit_out;
    @(posedge clock);
    #1;
    sample_point = 1'b0;
  endtask

  task automatic release_req(input string tag);
    @(negedge clock);
    Tx_request = 1'b0;
    @(posedge clock);
    #1;
    check_status(tag, 1'b1, 6'd0, 4'b0000);
    exp_q.delete();
  endtask

  initial begin
    logic [28:0] rid;
    reset_n = 1'b0; enable = 1'b1; sample_point = 1'b0; Tx_request = 1'b0;
    sof_complete = 1'b0; identifier = '0; ide = 1'b0; rtr = 1'b0; rx_bit = 1'b1;
    #12;
    check_status("reset", 1'b1, 6'd0, 4'b0000);
    @(negedge clock);
    reset_n = 1'b1;

    // Standard frame 0x563, mirrored bus.
    start_frame(29'h563, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) do_bit(i, 0, 1'b0);
    check_status("std_done", 1'b1, 6'd12, 4'b1000);
    release_req("std_release");

    // Extended frame with RTR.
    start_frame(29'h1ABCDE12, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 32; i++) do_bit(i, 0, 1'b0);
    check_status("ext_done", 1'b1, 6'd31, 4'b1000);
    release_req("ext_release");

    // Illegal standard ID.
    start_frame(29'h7F0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check_status("invalid", 1'b1, 6'd0, 4'b0001);
    release_req("invalid_release");

    // Arbitration lost at index 0.
    start_frame(29'h400, 1'b0, 1'b0, 1'b1);
    do_bit(0, 1, 1'b0);
    check_status("lost", 1'b1, 6'd0, 4'b0100);
    release_req("lost_release");

    // Bit error at index 1.
    start_frame(29'h400, 1'b0, 1'b0, 1'b1);
    do_bit(0, 0, 1'b0);
    do_bit(1, 1, 1'b1);
    check_status("biterr", 1'b1, 6'd1, 4'b0010);
    release_req("biterr_release");

    // Enable low mid-frame freezes everything, including conflicting samples.
    start_frame(29'h563, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) do_bit(i, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      enable       = 1'b0;
      sample_point = 1'b1;
      rx_bit       = ~bit_out;
      @(posedge clock);
      #1;
      sample_point = 1'b0;
      check("freeze_cnt", bit_counter, 6'd5);
      check("freeze_flags", {arb_complete, arb_lost, bit_error}, 3'b000);
    end
    @(negedge clock);
    enable = 1'b1;
    for (int i = 5; i < 13; i++) do_bit(i, 0, 1'b0);
    check_status("resume_done", 1'b1, 6'd12, 4'b1000);
    release_req("resume_release");

    // Abort beats a coincident sample point.
    start_frame(29'h563, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_bit(i, 0, 1'b0);
    @(negedge clock);
    Tx_request   = 1'b0;
    sample_point = 1'b1;
    rx_bit       = bit_out;
    @(posedge clock);
    #1;
    sample_point = 1'b0;
    check_status("abort", 1'b1, 6'd0, 4'b0000);
    exp_q.delete();

    // Asynchronous reset mid-frame at bit 7.
    start_frame(29'h563, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) do_bit(i, 0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_status("async_reset", 1'b1, 6'd0, 4'b0000);
    Tx_request = 1'b0;
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;

    // Three back-to-back random standard IDs.
    for (int f = 0; f < 3; f++) begin
      do rid = 29'($urandom_range(0, 2047)); while (rid[10:4] == 7'h7F);
      start_frame(rid, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 13; i++) do_bit(i, 0, 1'b0);
      check_status($sformatf("rand%0d_done", f), 1'b1, 6'd12, 4'b1000);
      release_req($sformatf("rand%0d_release", f));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
